// File: rtl/cpu32_mem_pkg.sv
// Shared CPU32 memory-side definitions: RAM arbiter state encoding, master ids
// and the RAM word count.
package cpu32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;

  localparam int unsigned RAM_WORDS = 262144;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select between the I and D masters. On a tie the
// master named by prio wins; a lone requester always wins.
module ram_arb_pick
  import cpu32_mem_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic prio,
  output logic any_req,
  output logic grant_id
);

  always_comb begin
    any_req  = i_req | d_req;
    grant_id = MST_I;
    if (i_req && d_req) begin
      grant_id = prio;
    end else if (d_req) begin
      grant_id = MST_D;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises CPU32 I-fetch and D load/store accesses onto the single-port RAM.
// Build option RAM_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise D has fixed priority.
module ram_arbiter
  import cpu32_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        d_req,
  input  logic        i_we,
  input  logic        d_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] d_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] d_wdata,
  output logic        i_ack,
  output logic        d_ack,
  output logic        i_err,
  output logic        d_err,
  output logic [31:0] i_rdata,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_r_addr,
  output logic [31:0] mem_w_addr,
  output logic [31:0] mem_w_line,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_r_line,
  input  logic        mem_rrdy,
  input  logic        mem_wrdy,
  input  logic        mem_exc
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cur_id, cur_id_nxt;
  logic             cur_we, cur_we_nxt;
  logic [31:0]      addr_nxt, wline_nxt;
  logic             mem_read_nxt, mem_write_nxt;
  logic             i_ack_nxt, i_err_nxt, d_ack_nxt, d_err_nxt;
  logic [31:0]      i_rdata_nxt, d_rdata_nxt;

  logic             any_req, grant_id, prio;
  logic             sel_we;
  logic [31:0]      sel_addr, sel_wdata;
  logic             sample, rd_ok, wr_ok, fail, done;

  ram_arb_pick u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .prio     (prio),
    .any_req  (any_req),
    .grant_id (grant_id)
  );

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // prio names the master that wins the next tie: the one not granted last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= MST_I;
    end else if (state == IDLE && any_req) begin
      prio <= ~grant_id;
    end
  end
`else
  assign prio = MST_D;
`endif

  assign sel_we    = (grant_id == MST_D) ? d_we    : i_we;
  assign sel_addr  = (grant_id == MST_D) ? d_addr  : i_addr;
  assign sel_wdata = (grant_id == MST_D) ? d_wdata : i_wdata;

  // The RAM's exc is sticky from the previous access, so the first ACCESS cycle is blind.
  assign sample = (cnt != '0);
  assign rd_ok  = sample && !cur_we && mem_rrdy;
  assign wr_ok  = sample &&  cur_we && mem_wrdy;
  assign fail   = (sample && mem_exc) || (cnt == CNT_LAST);
  assign done   = rd_ok || wr_ok || fail;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cur_id_nxt    = cur_id;
    cur_we_nxt    = cur_we;
    addr_nxt      = mem_r_addr;
    wline_nxt     = mem_w_line;
    mem_read_nxt  = mem_read;
    mem_write_nxt = mem_write;
    i_ack_nxt     = 1'b0;
    i_err_nxt     = 1'b0;
    d_ack_nxt     = 1'b0;
    d_err_nxt     = 1'b0;
    i_rdata_nxt   = i_rdata;
    d_rdata_nxt   = d_rdata;

    case (state)
      IDLE: begin
        if (any_req) begin
          cur_id_nxt    = grant_id;
          cur_we_nxt    = sel_we;
          addr_nxt      = sel_addr;
          wline_nxt     = sel_wdata;
          mem_read_nxt  = !sel_we;
          mem_write_nxt = sel_we;
          cnt_nxt       = '0;
          state_nxt     = ACCESS;
        end
      end

      ACCESS: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (done) begin
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          state_nxt     = RESP;
          if (cur_id == MST_D) begin
            d_ack_nxt = rd_ok || wr_ok;
            d_err_nxt = !(rd_ok || wr_ok);
            if (rd_ok) d_rdata_nxt = mem_r_line;
          end else begin
            i_ack_nxt = rd_ok || wr_ok;
            i_err_nxt = !(rd_ok || wr_ok);
            if (rd_ok) i_rdata_nxt = mem_r_line;
          end
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_id     <= MST_I;
      cur_we     <= 1'b0;
      mem_r_addr <= '0;
      mem_w_addr <= '0;
      mem_w_line <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      i_ack      <= 1'b0;
      i_err      <= 1'b0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cur_id     <= cur_id_nxt;
      cur_we     <= cur_we_nxt;
      mem_r_addr <= addr_nxt;
      mem_w_addr <= addr_nxt;
      mem_w_line <= wline_nxt;
      mem_read   <= mem_read_nxt;
      mem_write  <= mem_write_nxt;
      i_ack      <= i_ack_nxt;
      i_err      <= i_err_nxt;
      d_ack      <= d_ack_nxt;
      d_err      <= d_err_nxt;
      i_rdata    <= i_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: bench RAM, transaction-level arbiter model checked every cycle,
// and directed accesses with hand-computed expectations.
`timescale 1ns/1ps
module tb_ram_arbiter;
  import cpu32_mem_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, i_we = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, i_wdata = '0, d_wdata = '0;
  logic        i_ack, d_ack, i_err, d_err;
  logic [31:0] i_rdata, d_rdata, mem_r_addr, mem_w_addr, mem_w_line;
  logic        mem_read, mem_write;
  logic [31:0] mem_r_line = '0;
  logic        mem_rrdy = 1'b0, mem_wrdy = 1'b0, mem_exc = 1'b0;

  ram_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .d_req(d_req), .i_we(i_we), .d_we(d_we),
    .i_addr(i_addr), .d_addr(d_addr), .i_wdata(i_wdata), .d_wdata(d_wdata),
    .i_ack(i_ack), .d_ack(d_ack), .i_err(i_err), .d_err(d_err),
    .i_rdata(i_rdata), .d_rdata(d_rdata),
    .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr), .mem_w_line(mem_w_line),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_r_line(mem_r_line), .mem_rrdy(mem_rrdy), .mem_wrdy(mem_wrdy), .mem_exc(mem_exc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bench RAM: one-shot per strobe, data valid only in the rrdy cycle, sticky exc.
  logic [31:0] ram    [0:1023];
  logic [31:0] shadow [0:1023];
  logic        ram_busy = 1'b0;
  logic        ram_dead = 1'b0;

  always @(posedge clk) begin
    mem_rrdy   <= 1'b0;
    mem_wrdy   <= 1'b0;
    mem_r_line <= 32'h0BAD_F00D;
    if (!(mem_read || mem_write)) begin
      ram_busy <= 1'b0;
    end else if (!ram_busy) begin
      ram_busy <= 1'b1;
      if (!ram_dead) begin
        if ((mem_read ? mem_r_addr : mem_w_addr) >= RAM_WORDS) begin
          mem_exc <= 1'b1;
        end else begin
          mem_exc <= 1'b0;
          if (mem_read) begin
            mem_rrdy   <= 1'b1;
            mem_r_line <= ram[mem_r_addr[9:0]];
          end else begin
            mem_wrdy <= 1'b1;
            ram[mem_w_addr[9:0]] <= mem_w_line;
          end
        end
      end
    end
  end

  // Transaction model: a granted access finishes a fixed latency after the grant.
  int          phase = 0;
  int          m_left = 0;
  bit          m_prio = 1'b0;
  bit          m_id, m_we, m_dead, m_ok;
  logic [31:0] m_addr, m_wdata;
  logic        e_rd = 0, e_wr = 0, e_iack = 0, e_ierr = 0, e_dack = 0, e_derr = 0;
  logic [31:0] e_addr = '0, e_wline = '0, e_irdata = '0, e_drdata = '0;

  int cyc = 0;
  int last_grant_cyc = 0;
  int rd_hi = 0;
  bit prev_busy = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      phase = 0; m_prio = 1'b0;
      e_rd = 0; e_wr = 0; e_iack = 0; e_ierr = 0; e_dack = 0; e_derr = 0;
      e_addr = '0; e_wline = '0; e_irdata = '0; e_drdata = '0;
    end else begin
      e_iack = 0; e_ierr = 0; e_dack = 0; e_derr = 0;
      if (phase == 0) begin
        if (i_req || d_req) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
          m_id   = (i_req && d_req) ? m_prio : d_req;
          m_prio = !m_id;
`else
          m_id   = d_req;
`endif
          m_we    = m_id ? d_we : i_we;
          m_addr  = m_id ? d_addr : i_addr;
          m_wdata = m_id ? d_wdata : i_wdata;
          m_dead  = ram_dead;
          m_left  = m_dead ? TMO : 2;
          e_rd = !m_we; e_wr = m_we; e_addr = m_addr; e_wline = m_wdata;
          phase = 1;
        end
      end else if (phase == 1) begin
        m_left--;
        if (m_left == 0) begin
          e_rd = 0; e_wr = 0;
          m_ok = !m_dead && (m_addr < RAM_WORDS);
          if (m_ok && m_we) shadow[m_addr[9:0]] = m_wdata;
          if (m_id) begin
            e_dack = m_ok; e_derr = !m_ok;
            if (m_ok && !m_we) e_drdata = shadow[m_addr[9:0]];
          end else begin
            e_iack = m_ok; e_ierr = !m_ok;
            if (m_ok && !m_we) e_irdata = shadow[m_addr[9:0]];
          end
          phase = 2;
        end
      end else begin
        phase = 0;
      end
    end

    #1;
    cyc++;
    check_bit ("mem_read",   mem_read,   e_rd);
    check_bit ("mem_write",  mem_write,  e_wr);
    check_word("mem_r_addr", mem_r_addr, e_addr);
    check_word("mem_w_addr", mem_w_addr, e_addr);
    check_word("mem_w_line", mem_w_line, e_wline);
    check_bit ("i_ack",      i_ack,      e_iack);
    check_bit ("i_err",      i_err,      e_ierr);
    check_bit ("d_ack",      d_ack,      e_dack);
    check_bit ("d_err",      d_err,      e_derr);
    check_word("i_rdata",    i_rdata,    e_irdata);
    check_word("d_rdata",    d_rdata,    e_drdata);
    check_bit ("rd_wr_excl", mem_read && mem_write, 1'b0);
    if ((mem_read || mem_write) && !prev_busy) last_grant_cyc = cyc;
    prev_busy = mem_read || mem_write;
    if (mem_read) rd_hi++;
  end

  task automatic check_all_zero(input string tag);
    check_bit ({tag, "_mem_read"},  mem_read,   1'b0);
    check_bit ({tag, "_mem_write"}, mem_write,  1'b0);
    check_word({tag, "_r_addr"},    mem_r_addr, 32'h0);
    check_word({tag, "_w_addr"},    mem_w_addr, 32'h0);
    check_word({tag, "_w_line"},    mem_w_line, 32'h0);
    check_bit ({tag, "_acks"},      i_ack || d_ack, 1'b0);
    check_bit ({tag, "_errs"},      i_err || d_err, 1'b0);
    check_word({tag, "_i_rdata"},   i_rdata,    32'h0);
    check_word({tag, "_d_rdata"},   d_rdata,    32'h0);
  endtask

  task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output bit ak, output bit er, output int lat);
    @(negedge clk);
    rd_hi = 0;
    if (is_d) begin d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1; end
    else      begin i_we = we; i_addr = addr; i_wdata = wdata; i_req = 1'b1; end
    ak = 0; er = 0; lat = -1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (is_d ? (d_ack || d_err) : (i_ack || i_err)) begin
        ak  = is_d ? d_ack : i_ack;
        er  = is_d ? d_err : i_err;
        lat = cyc - last_grant_cyc;
        break;
      end
    end
    if (is_d) d_req = 1'b0; else i_req = 1'b0;
    check_bit("access_completed", lat >= 0, 1'b1);
  endtask

  // Waits for the next ack on either master; who = 1 for D.
  task automatic wait_any_ack(input string name, output bit who);
    bit got;
    got = 0; who = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin got = 1; who = d_ack; end
    end
    check_bit({name, "_seen"}, got, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ak, er, who;
    int lat;
    for (int k = 0; k < 1024; k++) begin
      ram[k]    = 32'hA500_0000 | 32'(k);
      shadow[k] = 32'hA500_0000 | 32'(k);
    end
    ram[16] = 32'hDEAD_BEEF;
    shadow[16] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Simultaneous requests held over four grants.
    @(negedge clk);
    i_we = 0; d_we = 0; i_addr = 32'h1; d_addr = 32'h2; i_req = 1; d_req = 1;
    for (int k = 0; k < 4; k++) begin
      wait_any_ack("tie", who);
`ifdef RAM_ARB_ROUND_ROBIN_EN
      check_bit($sformatf("tie_grant%0d", k), who, (k % 2) == 1);
`else
      check_bit($sformatf("tie_grant%0d", k), who, 1'b1);
`endif
    end
    i_req = 0; d_req = 0;
    check_word("tie_d_rdata", d_rdata, 32'hA500_0002);

    // D read of the preloaded word.
    access(1, 0, 32'h10, 32'h0, ak, er, lat);
    check_bit ("rd_ack", ak, 1'b1);
    check_bit ("rd_err", er, 1'b0);
    check_int ("rd_latency", lat, 2);
    check_int ("rd_strobe_cycles", rd_hi, 2);
    check_word("rd_data", d_rdata, 32'hDEAD_BEEF);

    // D write then I read-back.
    access(1, 1, 32'h20, 32'h1234_5678, ak, er, lat);
    check_bit ("wr_ack", ak, 1'b1);
    check_int ("wr_latency", lat, 2);
    access(0, 0, 32'h20, 32'h0, ak, er, lat);
    check_bit ("rb_ack", ak, 1'b1);
    check_word("rb_data", i_rdata, 32'h1234_5678);

    // Out-of-range read, then a clean read despite the sticky exc.
    access(1, 0, 32'h0004_0000, 32'h0, ak, er, lat);
    check_bit ("oor_err", er, 1'b1);
    check_bit ("oor_ack", ak, 1'b0);
    access(1, 0, 32'h0, 32'h0, ak, er, lat);
    check_bit ("after_oor_ack", ak, 1'b1);
    check_bit ("after_oor_err", er, 1'b0);
    check_word("after_oor_data", d_rdata, 32'hA500_0000);

    // Dead RAM: forced error completion.
    @(negedge clk);
    ram_dead = 1'b1;
    access(1, 0, 32'h5, 32'h0, ak, er, lat);
    check_bit("tmo_err", er, 1'b1);
    check_bit("tmo_ack", ak, 1'b0);
    check_int("tmo_latency", lat, TMO);
    check_int("tmo_strobe_cycles", rd_hi, TMO);
    ram_dead = 1'b0;

    // Reset one cycle into ACCESS.
    @(negedge clk);
    d_we = 0; d_addr = 32'h7; d_req = 1;
    for (int t = 0; t < 20 && !mem_read; t++) @(negedge clk);
    check_bit("mid_rst_granted", mem_read, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; d_req = 0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_bit("post_rst_quiet", i_ack || d_ack || i_err || d_err || mem_read || mem_write, 1'b0);
    end
    i_we = 0; d_we = 0; i_addr = 32'h3; d_addr = 32'h4; i_req = 1; d_req = 1;
    wait_any_ack("post_rst_tie", who);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    check_bit("post_rst_tie_grant", who, 1'b0);
`else
    check_bit("post_rst_tie_grant", who, 1'b1);
`endif
    i_req = 0; d_req = 0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
